// File: rtl/dmem_axi_if.sv
// Simplified AXI-style bus bundle for a single-beat data memory.
// Five channels (AR, R, AW, W, B); the slave modport is the memory side.
interface dmem_axi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // read address channel
    logic                AR_VALID;
    logic [ADDR_W-1:0]   AR_ADDR;
    logic                AR_READY;
    // read data channel
    logic                R_VALID;
    logic [DATA_W-1:0]   R_DATA;
    logic                R_READY;
    // write address channel
    logic                AW_VALID;
    logic [ADDR_W-1:0]   AW_ADDR;
    logic                AW_READY;
    // write data channel
    logic                W_VALID;
    logic [DATA_W-1:0]   W_DATA;
    logic [DATA_W/8-1:0] W_STRB;
    logic                W_READY;
    // write response channel
    logic                B_VALID;
    logic                B_READY;

    modport slave (
        input  AR_VALID, AR_ADDR,
        output AR_READY,
        output R_VALID, R_DATA,
        input  R_READY,
        input  AW_VALID, AW_ADDR,
        output AW_READY,
        input  W_VALID, W_DATA, W_STRB,
        output W_READY,
        output B_VALID,
        input  B_READY
    );

    modport master (
        output AR_VALID, AR_ADDR,
        input  AR_READY,
        input  R_VALID, R_DATA,
        output R_READY,
        output AW_VALID, AW_ADDR,
        input  AW_READY,
        output W_VALID, W_DATA, W_STRB,
        input  W_READY,
        input  B_VALID,
        output B_READY
    );
endinterface

// File: rtl/dmem_axi_slave.sv
// Word-addressed data memory behind a single-outstanding AXI-style slave.
// One FSM serialises reads and writes; a pending write wins over a read
// presented in the same idle cycle. Reads return after RD_LAT+1 cycles.
module dmem_axi_slave #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 10,
    parameter int RD_LAT = 2
) (
    input  logic        ACLK,
    input  logic        ARESETn,
    dmem_axi_if.slave   bus
);
    localparam int         STRB_W   = DATA_W / 8;
    localparam int         DEPTH    = 1 << MEM_AW;
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_WAIT    = 3'd1,
        S_RD_RESP    = 3'd2,
        S_WR_COLLECT = 3'd3,
        S_WR_EXEC    = 3'd4,
        S_WR_RESP    = 3'd5
    } state_t;

    // Address decode: upper bits must be zero for the word to exist.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return (a[ADDR_W-1:MEM_AW+2] == '0);
    endfunction

    function automatic logic [MEM_AW-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[MEM_AW+1:2];
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [MEM_AW-1:0]   rd_idx_q, rd_idx_d;
    logic                rd_inr_q, rd_inr_d;
    logic [MEM_AW-1:0]   wr_idx_q, wr_idx_d;
    logic                wr_inr_q, wr_inr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                aw_got_q, aw_got_d;
    logic                w_got_q, w_got_d;
    logic                r_valid_q, r_valid_d;
    logic [DATA_W-1:0]   r_data_q, r_data_d;
    logic                b_valid_q, b_valid_d;
    logic                mem_we_s;

    logic ar_ready_s, aw_ready_s, w_ready_s, wr_open_s;
    logic ar_hs_s, aw_hs_s, w_hs_s;

    // READY decode: combinational from state and latch flags, forced low in reset.
    always_comb begin
        wr_open_s  = ARESETn && ((state_q == S_IDLE) || (state_q == S_WR_COLLECT));
        ar_ready_s = ARESETn && (state_q == S_IDLE) && !bus.AW_VALID && !bus.W_VALID;
        aw_ready_s = wr_open_s && !aw_got_q;
        w_ready_s  = wr_open_s && !w_got_q;
        ar_hs_s    = bus.AR_VALID && ar_ready_s;
        aw_hs_s    = bus.AW_VALID && aw_ready_s;
        w_hs_s     = bus.W_VALID  && w_ready_s;
    end

    assign bus.AR_READY = ar_ready_s;
    assign bus.AW_READY = aw_ready_s;
    assign bus.W_READY  = w_ready_s;
    assign bus.R_VALID  = r_valid_q;
    assign bus.R_DATA   = r_data_q;
    assign bus.B_VALID  = b_valid_q;

    // Next-state, latch and response decode for the transaction FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rd_idx_d = rd_idx_q;
        rd_inr_d = rd_inr_q;
        wr_idx_d = wr_idx_q;
        wr_inr_d = wr_inr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        aw_got_d = aw_got_q;
        w_got_d  = w_got_q;
        r_data_d = r_data_q;
        mem_we_s = 1'b0;

        // AW and W are captured independently whenever their handshake fires.
        if (aw_hs_s) begin
            aw_got_d = 1'b1;
            wr_idx_d = addr_index(bus.AW_ADDR);
            wr_inr_d = addr_in_range(bus.AW_ADDR);
        end else begin
            aw_got_d = aw_got_q;
        end
        if (w_hs_s) begin
            w_got_d = 1'b1;
            wdata_d = bus.W_DATA;
            wstrb_d = bus.W_STRB;
        end else begin
            w_got_d = w_got_q;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.AW_VALID || bus.W_VALID) begin
                    if (aw_got_d && w_got_d) begin
                        state_d = S_WR_EXEC;
                    end else begin
                        state_d = S_WR_COLLECT;
                    end
                end else if (ar_hs_s) begin
                    rd_idx_d = addr_index(bus.AR_ADDR);
                    rd_inr_d = addr_in_range(bus.AR_ADDR);
                    if (RD_LAT_C != 4'd0) begin
                        state_d = S_RD_WAIT;
                        cnt_d   = RD_LAT_C;
                    end else begin
                        state_d  = S_RD_RESP;
                        r_data_d = addr_in_range(bus.AR_ADDR) ?
                                   mem_q[addr_index(bus.AR_ADDR)] : '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d  = S_RD_RESP;
                    cnt_d    = 4'd0;
                    r_data_d = rd_inr_q ? mem_q[rd_idx_q] : '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RD_RESP: begin
                if (bus.R_READY) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RD_RESP;
                end
            end
            S_WR_COLLECT: begin
                if (aw_got_d && w_got_d) begin
                    state_d = S_WR_EXEC;
                end else begin
                    state_d = S_WR_COLLECT;
                end
            end
            S_WR_EXEC: begin
                mem_we_s = 1'b1;
                aw_got_d = 1'b0;
                w_got_d  = 1'b0;
                state_d  = S_WR_RESP;
            end
            S_WR_RESP: begin
                if (bus.B_READY) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WR_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // VALIDs are registered images of the response states.
        r_valid_d = (state_d == S_RD_RESP);
        b_valid_d = (state_d == S_WR_RESP);
    end

    // FSM and latch registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            rd_idx_q  <= '0;
            rd_inr_q  <= 1'b0;
            wr_idx_q  <= '0;
            wr_inr_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
            b_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_idx_q  <= rd_idx_d;
            rd_inr_q  <= rd_inr_d;
            wr_idx_q  <= wr_idx_d;
            wr_inr_q  <= wr_inr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            b_valid_q <= b_valid_d;
        end
    end

    // Byte-lane write in WR_EXEC; out-of-range writes are dropped, contents never reset.
    always_ff @(posedge ACLK) begin
        if (mem_we_s && wr_inr_q) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[wr_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_axi_slave.sv
// Directed bench for dmem_axi_slave: a vector table of writes/reads with
// hand-computed results, plus sequences for ordering, priority and reset.
module tb_dmem_axi_slave;
    logic ACLK;
    logic ARESETn;
    int   checks = 0;
    int   errors = 0;

    dmem_axi_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_axi_slave #(.DATA_W(32), .ADDR_W(32), .MEM_AW(10), .RD_LAT(2)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus.slave)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        int bcnt;
        bit aw_hs;
        bit w_hs;
        @(negedge ACLK);
        bus.AW_VALID = 1'b1; bus.AW_ADDR = a;
        bus.W_VALID  = 1'b1; bus.W_DATA  = d; bus.W_STRB = s;
        bus.B_READY  = 1'b1;
        n = 0;
        while ((bus.AW_VALID || bus.W_VALID) && n < 50) begin
            #1;
            aw_hs = bus.AW_VALID && bus.AW_READY;
            w_hs  = bus.W_VALID && bus.W_READY;
            @(negedge ACLK);
            if (aw_hs) bus.AW_VALID = 1'b0;
            if (w_hs)  bus.W_VALID  = 1'b0;
            n++;
        end
        chk($sformatf("wr_accept_timeout_%h", a), 32'(n >= 50), 32'd0);
        bus.AW_VALID = 1'b0;
        bus.W_VALID  = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (bus.B_VALID) bcnt++;
            @(negedge ACLK);
        end
        chk($sformatf("b_count_%h", a), 32'(bcnt), 32'd1);
        bus.B_READY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output int lat, output int ar_wait);
        int n;
        @(negedge ACLK);
        bus.AR_VALID = 1'b1; bus.AR_ADDR = a; bus.R_READY = 1'b1;
        n = 0;
        #1;
        while (!bus.AR_READY && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        ar_wait = n;
        chk($sformatf("ar_timeout_%h", a), 32'(n >= 50), 32'd0);
        @(negedge ACLK);
        bus.AR_VALID = 1'b0;
        lat = 1;
        #1;
        while (!bus.R_VALID && lat < 40) begin
            @(negedge ACLK); #1; lat++;
        end
        d = bus.R_DATA;
        @(negedge ACLK); #1;
        chk($sformatf("r_valid_one_cycle_%h", a), 32'(bus.R_VALID), 32'd0);
        bus.R_READY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int lat;
        int arw;
        int n;
        int bcnt;

        bus.AR_VALID = 1'b0; bus.AR_ADDR = '0; bus.R_READY = 1'b0;
        bus.AW_VALID = 1'b0; bus.AW_ADDR = '0;
        bus.W_VALID  = 1'b0; bus.W_DATA  = '0; bus.W_STRB = '0;
        bus.B_READY  = 1'b0;
        ARESETn = 1'b0;

        // vector table: {is_wr, addr, data, strb, expected read data}
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'b1111, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,        4'b0000, 32'hDEADBEEF});
        vecs.push_back('{1'b1, 32'h0000_0040, 32'h11223344, 4'b1111, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0040, 32'hAABBCCDD, 4'b0101, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0040, 32'h0,        4'b0000, 32'h11BB33DD});
        vecs.push_back('{1'b0, 32'h0000_0043, 32'h0,        4'b0000, 32'h11BB33DD});
        vecs.push_back('{1'b1, 32'h0000_0004, 32'hCAFEF00D, 4'b1111, 32'h0});
        vecs.push_back('{1'b1, 32'h0001_0004, 32'h12345678, 4'b1111, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,        4'b0000, 32'hCAFEF00D});
        vecs.push_back('{1'b0, 32'h0001_0000, 32'h0,        4'b0000, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h0000_0044, 32'h01020304, 4'b1111, 32'h0});
        vecs.push_back('{1'b1, 32'h0000_0044, 32'h55667788, 4'b0000, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0044, 32'h0,        4'b0000, 32'h01020304});
        vecs.push_back('{1'b1, 32'h0000_0FFC, 32'hA5A5A5A5, 4'b1111, 32'h0});
        vecs.push_back('{1'b0, 32'h0000_0FFC, 32'h0,        4'b0000, 32'hA5A5A5A5});
        vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,        4'b0000, 32'h0000_0000});
        vecs.push_back('{1'b1, 32'h0000_0088, 32'h13572468, 4'b1111, 32'h0});

        // reset: READYs low while held, outputs cleared
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_ar_ready", 32'(bus.AR_READY), 32'd0);
        chk("rst_aw_ready", 32'(bus.AW_READY), 32'd0);
        chk("rst_w_ready",  32'(bus.W_READY),  32'd0);
        chk("rst_r_valid",  32'(bus.R_VALID),  32'd0);
        chk("rst_b_valid",  32'(bus.B_VALID),  32'd0);
        chk("rst_r_data",   bus.R_DATA,        32'h0);
        ARESETn = 1'b1;
        #1;
        chk("idle_ar_ready", 32'(bus.AR_READY), 32'd1);

        // table-driven transactions
        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                axi_read(vecs[i].addr, d, lat, arw);
                chk($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
                chk($sformatf("vec%0d_rlat", i), 32'(lat), 32'd3);
            end
        end

        // W three cycles ahead of AW: one response, one update
        @(negedge ACLK);
        bus.W_VALID = 1'b1; bus.W_DATA = 32'h0BADF00D; bus.W_STRB = 4'b1111;
        bus.B_READY = 1'b1;
        #1;
        chk("wfirst_w_ready", 32'(bus.W_READY), 32'd1);
        @(negedge ACLK);
        bus.W_VALID = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wfirst_w_ready_held", 32'(bus.W_READY), 32'd0);
            chk("wfirst_aw_ready", 32'(bus.AW_READY), 32'd1);
            if (bus.B_VALID) bcnt++;
            @(negedge ACLK);
        end
        bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h0000_0084;
        #1;
        chk("wfirst_aw_accept", 32'(bus.AW_READY), 32'd1);
        @(negedge ACLK);
        bus.AW_VALID = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.B_VALID) bcnt++;
            @(negedge ACLK);
        end
        chk("wfirst_b_count", 32'(bcnt), 32'd1);
        bus.B_READY = 1'b0;
        axi_read(32'h0000_0084, d, lat, arw);
        chk("wfirst_rdata", d, 32'h0BADF00D);

        // simultaneous AR and AW/W: write first, read right after B
        @(negedge ACLK);
        bus.AR_VALID = 1'b1; bus.AR_ADDR = 32'h0000_0088;
        bus.AW_VALID = 1'b1; bus.AW_ADDR = 32'h0000_0088;
        bus.W_VALID  = 1'b1; bus.W_DATA  = 32'h600DCAFE; bus.W_STRB = 4'b1111;
        bus.B_READY  = 1'b1;
        #1;
        chk("prio_ar_ready", 32'(bus.AR_READY), 32'd0);
        chk("prio_aw_ready", 32'(bus.AW_READY), 32'd1);
        chk("prio_w_ready",  32'(bus.W_READY),  32'd1);
        @(negedge ACLK);
        bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
        n = 0;
        #1;
        while (!bus.B_VALID && n < 10) begin
            @(negedge ACLK); #1; n++;
        end
        chk("prio_b_timeout", 32'(n >= 10), 32'd0);
        chk("prio_ar_ready_in_resp", 32'(bus.AR_READY), 32'd0);
        axi_read(32'h0000_0088, d, lat, arw);
        bus.B_READY = 1'b0;
        chk("prio_rdata", d, 32'h600DCAFE);
        chk("prio_b2b_accept", 32'(arw), 32'd0);

        // R stalled five cycles, then reset aborts the read
        @(negedge ACLK);
        bus.AR_VALID = 1'b1; bus.AR_ADDR = 32'h0000_0010; bus.R_READY = 1'b0;
        n = 0;
        #1;
        while (!bus.AR_READY && n < 20) begin
            @(negedge ACLK); #1; n++;
        end
        @(negedge ACLK);
        bus.AR_VALID = 1'b0;
        #1;
        while (!bus.R_VALID && n < 40) begin
            @(negedge ACLK); #1; n++;
        end
        chk("stall_r_timeout", 32'(n >= 40), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_r_valid", 32'(bus.R_VALID), 32'd1);
            chk("stall_r_data", bus.R_DATA, 32'hDEADBEEF);
            @(negedge ACLK); #1;
        end
        ARESETn = 1'b0;
        @(negedge ACLK); #1;
        chk("abort_r_valid", 32'(bus.R_VALID), 32'd0);
        chk("abort_r_data", bus.R_DATA, 32'h0);
        chk("abort_ar_ready", 32'(bus.AR_READY), 32'd0);
        ARESETn = 1'b1;
        axi_read(32'h0000_0010, d, lat, arw);
        chk("post_rst_rdata", d, 32'hDEADBEEF);
        chk("post_rst_rlat", 32'(lat), 32'd3);

        // reset in WR_COLLECT: W captured, no response, memory untouched
        @(negedge ACLK);
        bus.W_VALID = 1'b1; bus.W_DATA = 32'h0; bus.W_STRB = 4'b1111;
        @(negedge ACLK);
        bus.W_VALID = 1'b0;
        ARESETn = 1'b0;
        @(negedge ACLK); #1;
        chk("wabort_b_valid", 32'(bus.B_VALID), 32'd0);
        ARESETn = 1'b1;
        axi_write(32'h0000_0080, 32'h00000001, 4'b0001);
        axi_read(32'h0000_0010, d, lat, arw);
        chk("wabort_mem_kept", d, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_axi_slave.md
DMEM_AXI_SLAVE -- requirements
Module: dmem_axi_slave

Interface
REQ-001 Parameter DATA_W, 32, data width in bits; only 32 is supported.
REQ-002 Parameter ADDR_W, 32, address width in bits.
REQ-003 Parameter MEM_AW, 10, word-index width; memory depth is 2^MEM_AW words.
REQ-004 Parameter RD_LAT, 2, extra wait cycles between the AR handshake and R_VALID assertion; valid range 0..15.
REQ-005 ACLK  in  1  single clock; all logic on the rising edge.
REQ-006 ARESETn  in  1  reset, synchronous, active-low.
REQ-007 AR_VALID  in  1 / AR_ADDR  in  ADDR_W / AR_READY  out  1  read address channel.
REQ-008 R_VALID  out  1 / R_DATA  out  DATA_W / R_READY  in  1  read data channel, one beat per request.
REQ-009 AW_VALID  in  1 / AW_ADDR  in  ADDR_W / AW_READY  out  1  write address channel.
REQ-010 W_VALID  in  1 / W_DATA  in  DATA_W / W_STRB  in  DATA_W/8 / W_READY  out  1  write data channel.
REQ-011 B_VALID  out  1 / B_READY  in  1  write response channel; there is no response code.

Function
REQ-012 Storage SHALL be 2^MEM_AW words, indexed by ADDR[MEM_AW+1:2]; ADDR[1:0] is ignored.
REQ-013 An address is in range when ADDR[ADDR_W-1:MEM_AW+2] == 0.
- Out-of-range read: returns 32'h0.
- Out-of-range write: dropped, but the write is still handshaked and acknowledged.
REQ-014 The block SHALL use a single FSM with states IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_EXEC, WR_RESP; only one transaction is in flight at a time.
REQ-015 A handshake occurs on any cycle where VALID && READY are both high; all READY outputs are combinational from state and latch flags.
REQ-016 AR_READY = (STATE==IDLE) && !AW_VALID && !W_VALID; a pending write has priority over a simultaneous read.
REQ-017 AR handshake in IDLE:
- latch the word index and range flag;
- go to RD_WAIT if RD_LAT>0 (counter loaded with RD_LAT), else go to RD_RESP.
REQ-018 RD_WAIT: decrement the counter each cycle; on reaching 1, go to RD_RESP.
- Read latency from AR handshake to R_VALID high = RD_LAT+1 cycles.
REQ-019 R_DATA SHALL be registered from memory on entry to RD_RESP and held stable while R_VALID=1.
REQ-020 RD_RESP: R_VALID=1 until R_READY; on the handshake, R_VALID drops next cycle and the FSM returns to IDLE.
REQ-021 In IDLE, AW_VALID or W_VALID SHALL move the FSM to WR_COLLECT; the AW and W handshakes of that same cycle are accepted.
REQ-022 AW_READY = (IDLE||WR_COLLECT) && !aw_got, and W_READY = (IDLE||WR_COLLECT) && !w_got.
- AW and W are accepted independently, in either order or in the same cycle.
- Address, data and strobe are latched on their handshakes.
REQ-023 When both aw_got and w_got are set, or become set in the current cycle, go to WR_EXEC.
REQ-024 WR_EXEC (one cycle):
- write the bytes with W_STRB[i]=1 to byte lane i; bytes with strobe 0 keep their old value;
- no write if out of range; W_STRB=0 leaves memory unchanged;
- clear aw_got and w_got; go to WR_RESP.
REQ-025 WR_RESP: B_VALID=1 until B_READY; on the handshake, B_VALID drops next cycle and the FSM returns to IDLE.
REQ-026 A read issued after a write completes SHALL return the written data (read-after-write ordering).
REQ-027 VALID outputs, once asserted, SHALL NOT deassert before their handshake; held R_DATA SHALL NOT change.
REQ-028 Back-to-back transactions SHALL be accepted in the cycle after returning to IDLE; at most one idle cycle occurs between a response handshake and the next address acceptance.

Reset
REQ-029 When ARESETn=0 at a clock edge:
- STATE=IDLE; R_VALID=0, B_VALID=0, R_DATA=0;
- latch flags, latched address/data/strobe and counter cleared.
REQ-030 Reset mid-transaction (RD_WAIT, RD_RESP, WR_COLLECT, WR_RESP) SHALL abort it with no response issued; a write not yet in WR_EXEC SHALL NOT modify memory.
REQ-031 Memory contents are not reset; simulation initialises memory to 0.
REQ-032 All READY outputs SHALL be 0 while ARESETn=0.

Verification
REQ-033 RD_LAT=2, read of addr 0x10 (preloaded with 0xDEADBEEF), R_READY held 1 -> R_VALID rises 3 cycles after AR handshake with R_DATA=0xDEADBEEF, high for 1 cycle.
REQ-034 Full write of 0x11223344 to 0x40 (strobe 4'b1111), then write 0xAABBCCDD with strobe 4'b0101, then read 0x40 -> one B each; read returns 0x11BB33DD.
REQ-035 W presented 3 cycles before AW, then AW alone -> W accepted first, AW later; exactly one B_VALID pulse; memory updated once.
REQ-036 AR_VALID and AW_VALID/W_VALID asserted in the same IDLE cycle -> write accepted first (AR_READY=0); after B handshake the read is accepted and returns the new data.
REQ-037 Out-of-range read 0x0001_0000 and write 0x0001_0004 (MEM_AW=10) -> read returns 0x0; write gets B_VALID; word index 1 unchanged.
REQ-038 R_READY held 0 for 5 cycles in RD_RESP, then ARESETn pulsed low -> R_VALID/R_DATA stable until reset, then 0; next read behaves normally.
